counter_scan: RTL

4-digit hexadecimal up/down counter with a time-multiplexed 7-segment display controller. A prescaler produces count ticks that advance a 16-bit counter. A scan FSM shares one 7-segment decoder between four digits. It drives an active-low one-hot digit select, with a blanking gap between digits to suppress ghosting. The block sits between board switches/buttons and the top-level LED/segment pins.

---
 rtl/counter_scan_pkg.sv | 21 ++
 rtl/counter_seg.sv | 32 +++
 rtl/counter_scan.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/counter_scan_pkg.sv
// Shared types and constants for the hex up/down counter with multiplexed
// 7-segment display scan.
package counter_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-low one-hot digit select for digit idx.
    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/counter_seg.sv
// Combinational hex-to-7-segment decoder, active-low segments, bit6 = a ... bit0 = g.
module counter_seg
    import counter_scan_pkg::*;
(
    input  logic [3:0] i_num,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_num)
            4'h0: o_seg = 7'b0000001;
            4'h1: o_seg = 7'b1001111;
            4'h2: o_seg = 7'b0010010;
            4'h3: o_seg = 7'b0000110;
            4'h4: o_seg = 7'b1001100;
            4'h5: o_seg = 7'b0100100;
            4'h6: o_seg = 7'b0100000;
            4'h7: o_seg = 7'b0001111;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0000100;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b1100000;
            4'hC: o_seg = 7'b0110001;
            4'hD: o_seg = 7'b1000010;
            4'hE: o_seg = 7'b0110000;
            4'hF: o_seg = 7'b0111000;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/counter_scan.sv
// 16-bit hex up/down counter with prescaled count ticks and a BLANK/SHOW scan
// FSM that time-multiplexes one segment decoder across four digits.
module counter_scan
    import counter_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1000000,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_up,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic [15:0] o_cnt,
    output logic        o_carry,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg
);

    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned SW       = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SHOW_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);

    logic [PW-1:0]    r_pre;
    logic             w_tick;
    logic [15:0]      r_cnt;
    logic             r_carry;
    logic [15:0]      w_cnt_step;
    logic             w_wrap;

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [SW-1:0]    r_scan_cnt;
    logic [SW-1:0]    w_scan_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;

    logic [3:0]       w_nibble;
    logic [6:0]       w_glyph;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    assign w_tick     = i_en && (r_pre == PRE_LAST);
    assign w_cnt_step = i_up ? (r_cnt + 16'd1) : (r_cnt - 16'd1);
    assign w_wrap     = i_up ? (r_cnt == 16'hFFFF) : (r_cnt == 16'h0000);

    // Clear and load both restart the prescaler so the next tick is a full period away.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (i_clr || i_load) begin
            r_pre <= '0;
        end else if (i_en) begin
            r_pre <= w_tick ? '0 : (r_pre + PW'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= i_load_val;
            r_carry <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= w_cnt_step;
            r_carry <= w_wrap;
        end else begin
            r_carry <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_BLANK;
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_scan_cnt <= w_scan_cnt_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_scan_cnt_nxt = r_scan_cnt + SW'(1);
        w_idx_nxt      = r_idx;
        case (r_state)
            ST_BLANK: begin
                if (r_scan_cnt == BLANK_LAST) begin
                    w_state_nxt    = ST_SHOW;
                    w_scan_cnt_nxt = '0;
                end
            end
            ST_SHOW: begin
                if (r_scan_cnt == SHOW_LAST) begin
                    w_state_nxt    = ST_BLANK;
                    w_scan_cnt_nxt = '0;
                    w_idx_nxt      = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_BLANK;
                w_scan_cnt_nxt = '0;
                w_idx_nxt      = '0;
            end
        endcase
    end

    assign w_nibble = r_cnt[{r_idx, 2'b00} +: 4];

    counter_seg u_seg (
        .i_num (w_nibble),
        .o_seg (w_glyph)
    );

    // Anode and segment registers update together so no digit ever shows a stale glyph.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else if (r_state == ST_SHOW) begin
            r_an  <= an_select(r_idx);
            r_seg <= w_glyph;
        end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_carry = r_carry;
    assign o_an    = r_an;
    assign o_seg   = r_seg;

endmodule
